// File: rtl/mash_div_ctrl_pkg.sv
// Shared definitions for the MASH 1-1-1 divider controller and its register block.
package mash_div_ctrl_pkg;

    localparam int INT_W_DEF  = 8;
    localparam int FRAC_W_DEF = 24;
    localparam int WORD_W     = INT_W_DEF + FRAC_W_DEF;

    localparam int MOD_Y_W   = 4;
    localparam int MOD_Y_MIN = -3;
    localparam int MOD_Y_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RAMP = 2'd2
    } state_e;

endpackage

// File: rtl/mash_div_ctrl_if.sv
// Configuration handshake plus modulator/divider bus of the MASH divider controller.
interface mash_div_ctrl_if
    import mash_div_ctrl_pkg::*;
#(
    parameter int INT_W  = INT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [INT_W-1:0]   cfg_int;
    logic [FRAC_W-1:0]  cfg_frac;
    logic [FRAC_W-1:0]  cfg_step;
    logic [FRAC_W-1:0]  mod_x;
    logic [MOD_Y_W-1:0] mod_y;
    logic [INT_W-1:0]   div_ratio;
    logic               div_sat;
    logic               busy;
    logic               settled;

    modport master (
        output cfg_valid, cfg_int, cfg_frac, cfg_step, mod_y,
        input  cfg_ready, mod_x, div_ratio, div_sat, busy, settled
    );

    modport slave (
        input  cfg_valid, cfg_int, cfg_frac, cfg_step, mod_y,
        output cfg_ready, mod_x, div_ratio, div_sat, busy, settled
    );

endinterface

// File: rtl/mash_div_ctrl_div_ratio_sat.sv
// Registered stage: integer part plus signed modulator output, clamped to the legal modulus range.
module mash_div_ctrl_div_ratio_sat
    import mash_div_ctrl_pkg::*;
#(
    parameter int INT_W   = INT_W_DEF,
    parameter int DIV_MIN = 4,
    parameter int DIV_MAX = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INT_W-1:0]   int_i,
    input  logic [MOD_Y_W-1:0] mod_y_i,
    input  logic               mod_en_i,
    output logic [INT_W-1:0]   div_ratio_o,
    output logic               div_sat_o
);

    localparam logic signed [INT_W+1:0] MIN_S = (INT_W+2)'(DIV_MIN);
    localparam logic signed [INT_W+1:0] MAX_S = (INT_W+2)'(DIV_MAX);

    logic signed [INT_W+1:0] y_ext;
    logic signed [INT_W+1:0] sum;
    logic [INT_W-1:0]        ratio_d, ratio_q;
    logic                    sat_d, sat_q;

    always_comb begin
        y_ext   = mod_en_i ? {{(INT_W+2-MOD_Y_W){mod_y_i[MOD_Y_W-1]}}, mod_y_i} : '0;
        sum     = $signed({2'b00, int_i}) + y_ext;
        ratio_d = sum[INT_W-1:0];
        sat_d   = 1'b0;
        if (sum < MIN_S) begin
            ratio_d = INT_W'(DIV_MIN);
            sat_d   = 1'b1;
        end else if (sum > MAX_S) begin
            ratio_d = INT_W'(DIV_MAX);
            sat_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_q <= INT_W'(DIV_MIN);
            sat_q   <= 1'b0;
        end else begin
            ratio_q <= ratio_d;
            sat_q   <= sat_d;
        end
    end

    assign div_ratio_o = ratio_q;
    assign div_sat_o   = sat_q;

endmodule

// File: rtl/mash_div_ctrl.sv
// Fractional-N divider sequencer: accepts targets, slews the programmed word, feeds the modulator.
module mash_div_ctrl
    import mash_div_ctrl_pkg::*;
#(
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int INT_W   = INT_W_DEF,
    parameter int DIV_MIN = 4,
    parameter int DIV_MAX = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable_i,
    mash_div_ctrl_if.slave bus
);

    localparam int W = INT_W + FRAC_W;

    state_e            state_q, state_d;
    logic [W-1:0]      cur_q, cur_d;
    logic [W-1:0]      tgt_q, tgt_d;
    logic [FRAC_W-1:0] stp_q, stp_d;
    logic [FRAC_W-1:0] mod_x_q, mod_x_d;
    logic              settled_q, settled_d;

    logic              xfer;
    logic              ramp_up;
    logic [W-1:0]      cfg_w;
    logic [W-1:0]      stp_w;
    logic [W:0]        dist_cur, dist_cfg;
    logic [W:0]        stp_ext, cfg_stp_ext;

    function automatic logic [W:0] absDist(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[W] ? -d : d;
    endfunction

    assign cfg_w       = {bus.cfg_int, bus.cfg_frac};
    assign xfer        = bus.cfg_valid && (state_q != RAMP);
    assign stp_w       = {{INT_W{1'b0}}, stp_q};
    assign stp_ext     = {{(INT_W+1){1'b0}}, stp_q};
    assign cfg_stp_ext = {{(INT_W+1){1'b0}}, bus.cfg_step};
    assign dist_cur    = absDist(tgt_q, cur_q);
    assign dist_cfg    = absDist(cfg_w, cur_q);
    assign ramp_up     = tgt_q > cur_q;

    // Dropping enable beats everything; a simultaneous transfer still lands as an idle jump.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        stp_d     = stp_q;
        settled_d = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            if (xfer) begin
                tgt_d     = cfg_w;
                stp_d     = bus.cfg_step;
                cur_d     = cfg_w;
                settled_d = 1'b1;
            end else begin
                tgt_d = cur_q;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = HOLD;
                    if (xfer) begin
                        tgt_d     = cfg_w;
                        stp_d     = bus.cfg_step;
                        cur_d     = cfg_w;
                        settled_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        tgt_d = cfg_w;
                        stp_d = bus.cfg_step;
                        if (bus.cfg_step == '0 || dist_cfg <= cfg_stp_ext) begin
                            cur_d     = cfg_w;
                            settled_d = 1'b1;
                        end else begin
                            state_d = RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (dist_cur <= stp_ext) begin
                        cur_d     = tgt_q;
                        state_d   = HOLD;
                        settled_d = 1'b1;
                    end else begin
                        cur_d = ramp_up ? cur_q + stp_w : cur_q - stp_w;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        mod_x_d = (state_d == IDLE) ? '0 : cur_d[FRAC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            tgt_q     <= '0;
            stp_q     <= '0;
            mod_x_q   <= '0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            stp_q     <= stp_d;
            mod_x_q   <= mod_x_d;
            settled_q <= settled_d;
        end
    end

    mash_div_ctrl_div_ratio_sat #(
        .INT_W  (INT_W),
        .DIV_MIN(DIV_MIN),
        .DIV_MAX(DIV_MAX)
    ) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_i      (cur_q[W-1:FRAC_W]),
        .mod_y_i    (bus.mod_y),
        .mod_en_i   (state_q != IDLE),
        .div_ratio_o(bus.div_ratio),
        .div_sat_o  (bus.div_sat)
    );

    assign bus.cfg_ready = (state_q != RAMP);
    assign bus.busy      = (state_q == RAMP);
    assign bus.settled   = settled_q;
    assign bus.mod_x     = mod_x_q;

endmodule

// File: tb/tb_mash_div_ctrl.sv
// Scoreboard bench for mash_div_ctrl: directed targets, settle and modulus expectations queued.
module tb_mash_div_ctrl;
    import mash_div_ctrl_pkg::*;

    typedef struct {
        logic [23:0] modx;
        int          run;
    } settleExp_t;

    typedef struct {
        logic [7:0] ratio;
        logic       sat;
    } divExp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic divChk = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int runCnt     = 0;
    int lastRun    = 0;
    int waitCnt    = 0;

    settleExp_t settleQ[$];
    divExp_t    divQ[$];

    mash_div_ctrl_if #(.INT_W(8), .FRAC_W(24)) bus ();

    mash_div_ctrl #(
        .FRAC_W (24),
        .INT_W  (8),
        .DIV_MIN(4),
        .DIV_MAX(255)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable_i(enable),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_div_ratio"}, 32'(bus.div_ratio), 32'd4);
        checkOutput({tag, "_div_sat"}, 32'(bus.div_sat), 32'd0);
        checkOutput({tag, "_mod_x"}, 32'(bus.mod_x), 32'd0);
        checkOutput({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_settled"}, 32'(bus.settled), 32'd0);
    endtask

    task automatic applyStimulus(input logic en, input logic vld, input logic [7:0] ci,
                                 input logic [23:0] cf, input logic [23:0] cs,
                                 input logic [3:0] y, input logic chk);
        @(negedge clk);
        enable        = en;
        bus.cfg_valid = vld;
        bus.cfg_int   = ci;
        bus.cfg_frac  = cf;
        bus.cfg_step  = cs;
        bus.mod_y     = y;
        divChk        = chk;
    endtask

    // Monitor samples just after each active edge; busy runs are measured to check ramp length.
    initial begin
        settleExp_t s;
        divExp_t    d;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                runCnt  = 0;
                lastRun = 0;
            end else begin
                if (bus.busy) begin
                    runCnt++;
                    checkOutput("ready_low_in_ramp", 32'(bus.cfg_ready), 32'd0);
                end else if (runCnt != 0) begin
                    lastRun = runCnt;
                    runCnt  = 0;
                end
                if (!enable) lastRun = 0;
                if (bus.settled) begin
                    if (settleQ.size() == 0) begin
                        checkOutput("unexpected_settle", 32'(bus.settled), 32'd0);
                    end else begin
                        s = settleQ.pop_front();
                        checkOutput("settle_mod_x", 32'(bus.mod_x), 32'(s.modx));
                        checkOutput("settle_busy_cycles", 32'(lastRun), 32'(s.run));
                    end
                    lastRun = 0;
                end
                if (divChk) begin
                    if (divQ.size() == 0) begin
                        checkOutput("div_queue_empty", 32'(divChk), 32'd0);
                    end else begin
                        d = divQ.pop_front();
                        checkOutput("div_ratio", 32'(bus.div_ratio), 32'(d.ratio));
                        checkOutput("div_sat", 32'(bus.div_sat), 32'(d.sat));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_int   = '0;
        bus.cfg_frac  = '0;
        bus.cfg_step  = '0;
        bus.mod_y     = '0;
        repeat (2) @(negedge clk);
        checkResetState("init");
        rst_n = 1'b1;

        // Idle jump to 20.5, then enable and watch the modulus follow mod_y.
        settleQ.push_back('{24'h000000, 0});
        applyStimulus(1'b0, 1'b1, 8'd20, 24'h800000, 24'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        divQ.push_back('{8'd21, 1'b0});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd1, 1'b1);
        checkOutput("hold_mod_x", 32'(bus.mod_x), 32'h800000);
        divQ.push_back('{8'd19, 1'b0});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'hF, 1'b1);
        divQ.push_back('{8'd20, 1'b0});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b1);

        // 20.0 -> 21.0 at 1/16 per cycle, with a second target held valid during the ramp.
        settleQ.push_back('{24'h000000, 0});
        applyStimulus(1'b1, 1'b1, 8'd20, 24'h0, 24'h0, 4'd0, 1'b0);
        settleQ.push_back('{24'h000000, 16});
        applyStimulus(1'b1, 1'b1, 8'd21, 24'h0, 24'h100000, 4'd0, 1'b0);
        settleQ.push_back('{24'h800000, 0});
        applyStimulus(1'b1, 1'b1, 8'd21, 24'h800000, 24'h0, 4'd0, 1'b0);
        waitCnt = 0;
        while (!bus.cfg_ready && waitCnt < 40) begin
            waitCnt++;
            @(negedge clk);
        end
        checkOutput("ramp_ready_low_cycles", 32'(waitCnt), 32'd16);
        divQ.push_back('{8'd21, 1'b0});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b1);

        // Saturation at both ends of the modulus range.
        settleQ.push_back('{24'h000000, 0});
        applyStimulus(1'b1, 1'b1, 8'd4, 24'h0, 24'h0, 4'd0, 1'b0);
        divQ.push_back('{8'd4, 1'b1});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'(MOD_Y_MIN), 1'b1);
        divQ.push_back('{8'd8, 1'b0});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'(MOD_Y_MAX), 1'b1);
        settleQ.push_back('{24'h000000, 0});
        applyStimulus(1'b1, 1'b1, 8'd254, 24'h0, 24'h0, 4'd0, 1'b0);
        divQ.push_back('{8'd255, 1'b1});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'(MOD_Y_MAX), 1'b1);
        divQ.push_back('{8'd251, 1'b0});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'(MOD_Y_MIN), 1'b1);
        divQ.push_back('{8'd255, 1'b0});
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd1, 1'b1);

        // Abandon a ramp after five steps: word freezes at 20 + 0x500000, no settle.
        settleQ.push_back('{24'h000000, 0});
        applyStimulus(1'b1, 1'b1, 8'd20, 24'h0, 24'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd21, 24'h0, 24'h100000, 4'd0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        divQ.push_back('{8'd20, 1'b0});
        applyStimulus(1'b0, 1'b0, 8'd0, 24'h0, 24'h0, 4'(MOD_Y_MAX), 1'b1);
        checkOutput("abandon_mod_x", 32'(bus.mod_x), 32'd0);
        checkOutput("abandon_busy", 32'(bus.busy), 32'd0);
        checkOutput("abandon_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        checkOutput("frozen_mod_x", 32'(bus.mod_x), 32'h500000);
        checkOutput("frozen_busy", 32'(bus.busy), 32'd0);

        // Transfer on the same edge enable falls: idle jump despite a nonzero step.
        settleQ.push_back('{24'h000000, 0});
        applyStimulus(1'b0, 1'b1, 8'd30, 24'h0, 24'h100000, 4'd0, 1'b0);
        divQ.push_back('{8'd30, 1'b0});
        applyStimulus(1'b0, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b1);
        checkOutput("idle_jump_mod_x", 32'(bus.mod_x), 32'd0);

        // Asynchronous reset in the middle of a long ramp.
        applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd40, 24'h0, 24'h100000, 4'd0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'd0, 24'h0, 24'h0, 4'd0, 1'b0);
        checkOutput("ramp_busy_before_reset", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetState("mid_ramp_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("settle_queue_drained", 32'(settleQ.size()), 32'd0);
        checkOutput("div_queue_drained", 32'(divQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
